// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared BCD constants, digit type, sequencer state encoding and digit helpers
// for the serial BCD adder.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_ADJ     = 6;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic digit_invalid(bcd_digit_t d);
        return (d > bcd_digit_t'(BCD_MAX));
    endfunction

    // Out-of-range digits wrap here, which keeps subtraction of bad input deterministic.
    function automatic bcd_digit_t nines_comp(bcd_digit_t d);
        return bcd_digit_t'(BCD_MAX) - d;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result handshake bundle for bcd_serial_add_ctrl.
// The sub port exists only when BCD_SUB_EN is defined.
interface bcd_serial_add_ctrl_if #(parameter int DIGITS = 4);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  cin;
`ifdef BCD_SUB_EN
    logic                  sub;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum_bcd;
    logic                  cout;
    logic                  err;
    logic                  busy;

    modport master (
        output in_valid, a_bcd, b_bcd, cin, out_ready,
`ifdef BCD_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum_bcd, cout, err, busy
    );

    modport slave (
        input  in_valid, a_bcd, b_bcd, cin, out_ready,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum_bcd, cout, err, busy
    );

endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Single-digit BCD adder with decimal correction; purely combinational and
// shared across all digit positions by the sequencer.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    logic [4:0] s5_s;

    // Binary digit sum, then +6 correction whenever it exceeds nine
    always_comb begin
        s5_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s5_s > 5'(BCD_MAX)) begin
            digit = s5_s[3:0] + 4'(BCD_ADJ);
            cout  = 1'b1;
        end else begin
            digit = s5_s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit adder, LSD first, valid/ready
// on both sides. Define BCD_SUB_EN to add ten's-complement subtraction.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_serial_add_ctrl_if.slave    bus
);

    localparam int W    = BCD_DIGIT_W * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              in_ready_q, out_valid_q, busy_q;

    logic [W-1:0]      b_in_s;
    logic              cin_in_s;
    logic              err_in_s;
    bcd_digit_t        dig_a_s, dig_b_s, dig_sum_s;
    logic              dig_cout_s;

    // Operand conditioning at accept: invalid-digit scan and optional complement of B
    always_comb begin
        err_in_s = 1'b0;
        b_in_s   = bus.b_bcd;
        cin_in_s = bus.cin;
        for (int i = 0; i < DIGITS; i++) begin
            err_in_s = err_in_s
                     | digit_invalid(bus.a_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W])
                     | digit_invalid(bus.b_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
        end
`ifdef BCD_SUB_EN
        if (bus.sub) begin
            for (int i = 0; i < DIGITS; i++) begin
                b_in_s[BCD_DIGIT_W*i +: BCD_DIGIT_W] =
                    nines_comp(bus.b_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
            end
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = bus.b_bcd;
            cin_in_s = bus.cin;
        end
`endif
    end

    assign dig_a_s = a_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
    assign dig_b_s = b_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];

    bcd_digit_add u_digit_add (
        .a     (dig_a_s),
        .b     (dig_b_s),
        .cin   (carry_q),
        .digit (dig_sum_s),
        .cout  (dig_cout_s)
    );

    // Sequencer next-state: accept, walk the digits, then hold until the result is taken
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_bcd;
                    b_d     = b_in_s;
                    carry_d = cin_in_s;
                    idx_d   = '0;
                    err_d   = err_in_s;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                sum_d[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W] = dig_sum_s;
                carry_d = dig_cout_s;
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    cout_d  = dig_cout_s;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; handshake outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_bcd   = sum_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with DIGITS=4; subtraction vectors run
// only when BCD_SUB_EN is defined.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic present(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        bus.a_bcd    = a;
        bus.b_bcd    = b;
        bus.cin      = c;
`ifdef BCD_SUB_EN
        bus.sub      = s;
`else
        if (s) $display("note: sub requested without BCD_SUB_EN");
        else   bus.cin = c;
`endif
        bus.in_valid = 1'b1;
    endtask

    // Accepts one operand set, waits (bounded) for out_valid and checks the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_err);
        int lat;
        present(a, b, c, s);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(bus.sum_bcd), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        if (bus.out_ready) begin
            tick();
            check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
            check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_bcd     = 16'h0000;
        bus.b_bcd     = 16'h0000;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef BCD_SUB_EN
        bus.sub       = 1'b0;
`endif
        tick();
        present(16'h1111, 16'h1111, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum_bcd), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("t2a", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t2b", 16'h0958, 16'h0047, 1'b1, 1'b0, 16'h1006, 1'b0, 1'b0);
        run_op("t3", 16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1);

        // Backpressure: result held, new operands refused
        bus.out_ready = 1'b0;
        run_op("t4", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            present(16'h7777, 16'h1111, 1'b1, 1'b0);
            bus.in_valid = (i % 2 == 0);
            tick();
            check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t4_hold_sum", 32'(bus.sum_bcd), 32'h3333);
            check("t4_hold_cout", 32'(bus.cout), 32'd0);
            check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("t4_release_idle", 32'(bus.in_ready), 32'd1);
        check("t4_release_ov", 32'(bus.out_valid), 32'd0);
        run_op("t4_next", 16'h0005, 16'h0006, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);

        // Reset asserted at the second ADD edge aborts the operation
        present(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_ov", 32'(bus.out_valid), 32'd0);
        check("t5_sum", 32'(bus.sum_bcd), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        run_op("t5_after", 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        run_op("t6a", 16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0);
        run_op("t6b", 16'h0123, 16'h0500, 1'b0, 1'b1, 16'h9623, 1'b0, 1'b0);
        bus.sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
